// File: rtl/jt12_i2s_tx.sv
// I2S transmitter: one 32-bit {L,R} frame per 32 sclk periods, MSB first,
// with the standard one-bit delay after each lrck change.
module jt12_i2s_tx #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic [15:0] left,
  input  logic [15:0] right,
  input  logic        mute,
  output logic        sclk,
  output logic        lrck,
  output logic        sdata,
  output logic        frame_start,
  output logic        overrun
);

  logic [7:0]  r_div;
  logic [4:0]  r_slot;
  logic [31:0] r_hold;
  logic [31:0] r_w;
  logic        r_pend;
  logic        r_sclk, r_lrck, r_sdata, r_fs, r_ov;

  logic        w_wrap, w_fall, w_load;
  logic [4:0]  w_nslot;

  assign w_wrap  = (r_div == 8'(DIV - 1));
  assign w_fall  = w_wrap & r_sclk;
  assign w_load  = w_fall & (r_slot == 5'd31);
  assign w_nslot = r_slot + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_sclk  <= 1'b0;
      r_slot  <= '0;
      r_lrck  <= 1'b0;
      r_sdata <= 1'b0;
    end else begin
      r_div <= w_wrap ? 8'd0 : r_div + 8'd1;
      if (w_wrap) r_sclk <= ~r_sclk;
      if (w_fall) begin
        r_slot  <= w_nslot;
        r_lrck  <= w_nslot[4];
        // entering slot k emits W[32-k]; 31-slot == ~slot, slot 0 gets old W[0]
        r_sdata <= r_w[~r_slot];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
      r_w    <= '0;
      r_pend <= 1'b0;
      r_fs   <= 1'b0;
      r_ov   <= 1'b0;
    end else begin
      r_fs <= w_load;
      r_ov <= sample & r_pend & ~w_load;
      // a load reads the old holding word; a coincident sample becomes the next pending one
      if (w_load) begin
        if (mute)        r_w <= '0;
        else if (r_pend) r_w <= r_hold;
      end
      if (sample) begin
        r_hold <= {left, right};
        r_pend <= 1'b1;
      end else if (w_load) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign sclk        = r_sclk;
  assign lrck        = r_lrck;
  assign sdata       = r_sdata;
  assign frame_start = r_fs;
  assign overrun     = r_ov;

endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Directed bench for jt12_i2s_tx at DIV=4: reset timing, frame serialisation,
// overrun, repeat, mute, load-cycle sample and mid-frame reset.
module tb_jt12_i2s_tx;
  localparam int DIV = 4;
  localparam int SLT = 2 * DIV;
  localparam int FRM = 64 * DIV;

  logic        clk = 1'b0, rst = 1'b0, sample = 1'b0, mute = 1'b0;
  logic [15:0] left = '0, right = '0;
  logic        sclk, lrck, sdata, frame_start, overrun;

  jt12_i2s_tx #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .sample(sample), .left(left), .right(right), .mute(mute),
    .sclk(sclk), .lrck(lrck), .sdata(sdata), .frame_start(frame_start), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit en, input logic [31:0] d);
    sample = en;
    if (en) {left, right} = d;
  endtask

  // Hold reset, release, and check timing of the first frame (ends on the first load edge).
  task automatic rst_phase(input bit smp, input logic [31:0] d);
    int rise = -1, fall = -1, lr1 = -1, fs = -1, nz = 0;
    bit ps = 1'b0;
    rst = 1'b0;
    repeat (3) step;
    chk("rst_outs", {27'd0, sclk, lrck, sdata, frame_start, overrun}, 32'd0);
    rst = 1'b1;
    for (int c = 1; c <= FRM; c++) begin
      drive(smp && c == 10, d);
      step;
      drive(1'b0, '0);
      if (sclk && !ps && rise < 0) rise = c;
      if (!sclk && ps && fall < 0) fall = c;
      ps = sclk;
      if (lrck && lr1 < 0) lr1 = c;
      if (frame_start && fs < 0) fs = c;
      if (sdata) nz++;
    end
    chk("first_rise", rise, 32'd4);
    chk("first_fall", fall, 32'd8);
    chk("first_lrck1", lr1, 32'd128);
    chk("first_load", fs, 32'd256);
    chk("frame0_zero", nz, 32'd0);
  endtask

  // Starting at a load edge, capture one full frame up to and including the next load edge.
  task automatic get_frame(input string tag, input int p1, input logic [31:0] d1,
                           input int p2, input logic [31:0] d2,
                           input logic [31:0] exp_w, input int exp_ov);
    logic [31:0] w, lr;
    int ov = 0, fs = 0, k;
    w = '0; lr = '0;
    for (int c = 1; c <= FRM; c++) begin
      if (c == p1)      drive(1'b1, d1);
      else if (c == p2) drive(1'b1, d2);
      else              drive(1'b0, '0);
      step;
      drive(1'b0, '0);
      if (overrun) ov++;
      if (frame_start) fs++;
      if (c % SLT == 0) begin
        k = (c / SLT) % 32;
        w[(32 - k) % 32] = sdata;
        lr[k] = lrck;
      end
    end
    chk({tag, "_word"}, w, exp_w);
    chk({tag, "_lrck"}, lr, 32'hFFFF0000);
    chk({tag, "_ovr"}, ov, exp_ov);
    chk({tag, "_fs"}, fs, 32'd1);
  endtask

  initial begin
    rst_phase(1'b1, 32'hA55A0F0F);
    get_frame("basic", 24, 32'h12345678, 100, 32'h9ABCDEF0, 32'hA55A0F0F, 1);
    get_frame("ovr_nx", 0, '0, 0, '0, 32'h9ABCDEF0, 0);
    get_frame("repeat", 0, '0, 0, '0, 32'h9ABCDEF0, 0);
    mute = 1'b1;
    get_frame("mute_mid", 40, 32'hCAFEBABE, 0, '0, 32'h9ABCDEF0, 0);
    mute = 1'b0;
    get_frame("mute_zero", 0, '0, 0, '0, 32'h0, 0);
    get_frame("mute_rep", 24, 32'h33334444, FRM, 32'h55556666, 32'h0, 0);
    get_frame("simul_old", 0, '0, 0, '0, 32'h33334444, 0);
    get_frame("simul_new", 0, '0, 0, '0, 32'h55556666, 0);

    repeat (20 * SLT + 2) step;
    chk("slot20_lrck", lrck, 32'd1);
    rst = 1'b0;
    #2;
    chk("async_rst", {29'd0, sclk, lrck, sdata}, 32'd0);
    rst_phase(1'b0, '0);
    get_frame("post_rst", 0, '0, 0, '0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jt12_i2s_tx.md
JT12_I2S_TX -- requirements
Module: jt12_i2s_tx

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clk cycles per sclk half-period; legal range 2..255.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sample  input  1  one-cycle strobe: left/right valid.
REQ-005 SHALL have port left  input  16  signed PCM, left channel.
REQ-006 SHALL have port right  input  16  signed PCM, right channel.
REQ-007 SHALL have port mute  input  1  force transmitted word to zero.
REQ-008 SHALL have port sclk  output  1  serial bit clock to DAC.
REQ-009 SHALL have port lrck  output  1  word select: 0 = left, 1 = right.
REQ-010 SHALL have port sdata  output  1  serial data, MSB first, I2S one-bit delay.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse when a frame word is loaded.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when an unconsumed sample is overwritten.

Function
REQ-013 SHALL run an 8-bit divider counting 0..DIV-1 and wrapping; sclk toggles on the cycle the counter wraps, giving an sclk period of 2*DIV clk cycles.
REQ-014 SHALL keep a 5-bit slot counter, 0..31, advanced on each sclk falling toggle and wrapping 31->0; one frame = 32 slots = 64*DIV clk cycles.
REQ-015 SHALL drive lrck=0 in slots 0..15 and lrck=1 in slots 16..31; lrck changes with the sclk falling toggle.
REQ-016 SHALL serialise frame word W={L,R} (32 bits) as follows: slot k, for k=1..31, carries W[32-k]; slot 0 carries R[0] of the previous frame.
REQ-017 SHALL change sdata only together with the sclk falling toggle, so it is stable across the sclk rising edge.
REQ-018 SHALL capture left/right into a holding register and set a pending flag on any cycle with sample=1.
REQ-019 SHALL perform a load on the falling toggle entering slot 0.
REQ-020 SHALL, at a load, act on W, pending and frame_start as follows:
- W <= 0 if mute=1;
- else W <= holding if pending=1;
- else W keeps its old value (repeat last word);
- pending cleared;
- frame_start=1 for that cycle.
REQ-021 SHALL, when sample and a load occur in the same cycle, give W the pre-existing holding contents; the new sample then enters holding with pending=1 and does not pulse overrun.
REQ-022 SHALL pulse overrun for one cycle when sample=1 while pending=1 and no load occurs that cycle; the holding register takes the newer sample.
REQ-023 SHALL sample mute only at load cycles; mute changes mid-frame do not affect the frame in progress.
REQ-024 SHALL treat left/right as raw bits: no saturation, scaling or sign handling.

Reset
REQ-025 SHALL, while rst=0, asynchronously force all of the following to 0: sclk, lrck, sdata, frame_start, overrun, divider, slot counter, holding, W and pending.
REQ-026 SHALL, after rst release, give the first sclk rise at clk cycle DIV, the first fall (entering slot 1) at cycle 2*DIV, and the first load at cycle 64*DIV.
REQ-027 SHALL transmit all-zero data during the first frame after reset.
REQ-028 SHALL, on reset mid-frame, abandon the frame and restart timing from slot 0 with zeros after release.

Verification (DIV=4)
REQ-029 SHALL verify reset: hold rst=0, toggle clk -> all outputs 0; release -> sclk rises at cycle 4, falls at 8; lrck stays 0 until cycle 128.
REQ-030 SHALL verify a basic frame: sample with left=16'hA55A, right=16'h0F0F at cycle 10 -> frame_start at cycle 256; the next frame's slots 1..16 carry 1010010101011010 with lrck=0 in slots 0..15; slots 17..31 plus the following slot 0 carry 0000111100001111 with lrck=1 in slots 16..31.
REQ-031 SHALL verify overrun: two samples within one frame (1234/5678, then 9ABC/DEF0) -> overrun pulses once, on the second sample; the next frame carries 9ABC/DEF0.
REQ-032 SHALL verify repeat: no sample during a frame -> the next frame repeats the previous word bit-exactly, and frame_start still pulses.
REQ-033 SHALL verify mute and the simultaneous case:
- pending word with mute=1 at load -> frame all zeros and pending cleared; a later load with mute=0 and no new sample -> zeros repeated;
- sample on the load cycle -> the old holding word goes out this frame and the new word goes out next frame, with overrun=0.
REQ-034 SHALL verify mid-frame reset: assert rst=0 in slot 20 -> sclk, lrck and sdata go 0 immediately, with no waiting for a clk edge; after release, timing matches REQ-026.
